// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target responder.
// Optional build macro used by the top level: I2C_CLOCK_STRETCH_EN.
package i2c_pkg;

    // Protocol state of the target.
    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WRITE,
        WRITE_ACK,
        READ,
        READ_ACK,
        WAIT_STOP
    } i2c_state_e;

    // Data bits per byte on the wire (the ACK slot is the 9th clock).
    localparam logic [3:0] BITS_PER_BYTE = 4'd8;

    // SDA levels seen in the acknowledge slot.
    localparam logic ACK_LEVEL  = 1'b0;
    localparam logic NACK_LEVEL = 1'b1;

    // Address match; the general-call address (0) is never claimed.
    function automatic logic addr_hit(input logic [6:0] rx_addr, input logic [6:0] own_addr);
        return (rx_addr == own_addr) && (rx_addr != 7'd0);
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes the SCL/SDA pad inputs into the clock domain and derives
// SCL edge strobes plus START/STOP strobes. A bus condition is only
// reported when SCL is stable high across the sampled SDA edge, so an SCL
// and SDA change landing in the same clock is treated as ordinary data.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2   // at least 2
) (
    input  logic clock,
    input  logic Reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda_level,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_prev_q, scl_prev_d;
    logic                   sda_prev_q, sda_prev_d;
    logic                   scl_now, sda_now;

    assign scl_now = scl_sync_q[SYNC_STAGES-1];
    assign sda_now = sda_sync_q[SYNC_STAGES-1];

    // Next-state for the synchronizer chains and the edge-detect register.
    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
        scl_prev_d = scl_now;
        sda_prev_d = sda_now;
    end

    // Registers reset to the idle (released, high) bus level so that reset
    // release never fabricates an edge.
    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
        end
    end

    assign sda_level = sda_now;
    assign scl_rise  = scl_now & ~scl_prev_q;
    assign scl_fall  = ~scl_now & scl_prev_q;
    assign start_det = scl_now & scl_prev_q & ~sda_now & sda_prev_q;
    assign stop_det  = scl_now & scl_prev_q & sda_now & ~sda_prev_q;

endmodule

// File: rtl/i2c_target_responder.sv
// I2C target: address match, ACK generation, byte receive and transmit.
// Build macro I2C_CLOCK_STRETCH_EN adds the TxReady input and lets the
// target hold SCL low until the user has the next read byte ready.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | bus idle or not ours, waiting for START
// ADDR      | shifting in address + R/W bit
// ADDR_ACK  | driving address ACK; its trailing fall starts write or read
// WRITE     | shifting in a data byte from the master
// WRITE_ACK | driving ACK for the received byte
// READ      | shifting out a data byte, one bit per SCL fall
// READ_ACK  | sampling the master's ACK/NACK for the byte just sent
// WAIT_STOP | not addressed or master NACKed; wait for STOP/START
module i2c_target_responder
    import i2c_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       Reset,
    input  logic       SCL_In,
    input  logic       SDA_In,
    output logic       SDA_Low,
    output logic       SCL_Low,
    output logic [7:0] RxData,
    output logic       RxValid,
    input  logic [7:0] TxData,
    output logic       TxLoad,
`ifdef I2C_CLOCK_STRETCH_EN
    input  logic       TxReady,
`endif
    output logic       Busy,
    output logic       ReadMode
);

    logic sda_level, scl_rise, scl_fall, start_det, stop_det;

    i2c_line_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_line_sync (
        .clock    (clock),
        .Reset    (Reset),
        .scl_in   (SCL_In),
        .sda_in   (SDA_In),
        .sda_level(sda_level),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start_det(start_det),
        .stop_det (stop_det)
    );

    i2c_state_e state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] shift_q, shift_d;        // first seven bits of the byte in flight
    logic [6:0] tx_shift_q, tx_shift_d;  // read bits not yet driven, MSB first
    logic       sda_low_q, sda_low_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_load_q, tx_load_d;
    logic       busy_q, busy_d;
    logic       read_mode_q, read_mode_d;
    // Second half of an ACK slot (ADDR_ACK/WRITE_ACK), or master-ACK seen (READ_ACK).
    logic       phase_q, phase_d;
    logic       load_req;
    logic [7:0] byte_in;
`ifdef I2C_CLOCK_STRETCH_EN
    logic       scl_low_q, scl_low_d;
    logic       stretch_q, stretch_d;
`endif

    assign byte_in = {shift_q, sda_level};

    // Next-state and output logic of the protocol FSM.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        tx_shift_d  = tx_shift_q;
        sda_low_d   = sda_low_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        tx_load_d   = 1'b0;
        busy_d      = busy_q;
        read_mode_d = read_mode_q;
        phase_d     = phase_q;
        load_req    = 1'b0;
`ifdef I2C_CLOCK_STRETCH_EN
        scl_low_d   = scl_low_q;
        stretch_d   = stretch_q;
`endif

        if (start_det || stop_det) begin
            state_d   = start_det ? ADDR : IDLE;
            bit_cnt_d = 4'd0;
            sda_low_d = 1'b0;
            busy_d    = 1'b0;
            phase_d   = 1'b0;
`ifdef I2C_CLOCK_STRETCH_EN
            scl_low_d = 1'b0;
            stretch_d = 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                end

                ADDR: begin
                    if (scl_rise) begin
                        shift_d = byte_in[6:0];
                        if (bit_cnt_q == BITS_PER_BYTE - 4'd1) begin
                            bit_cnt_d = 4'd0;
                            if (addr_hit(byte_in[7:1], TARGET_ADDR)) begin
                                read_mode_d = byte_in[0];
                                busy_d      = 1'b1;
                                phase_d     = 1'b0;
                                state_d     = ADDR_ACK;
                            end else begin
                                state_d = WAIT_STOP;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end

                ADDR_ACK: begin
`ifdef I2C_CLOCK_STRETCH_EN
                    if (stretch_q) begin
                        if (TxReady) begin
                            stretch_d = 1'b0;
                            load_req  = 1'b1;
                        end
                    end else
`endif
                    if (scl_fall) begin
                        if (!phase_q) begin
                            sda_low_d = ~ACK_LEVEL;
                            phase_d   = 1'b1;
                        end else begin
                            phase_d = 1'b0;
                            if (read_mode_q) begin
                                load_req = 1'b1;
                            end else begin
                                sda_low_d = 1'b0;
                                bit_cnt_d = 4'd0;
                                state_d   = WRITE;
                            end
                        end
                    end
                end

                WRITE: begin
                    if (scl_rise) begin
                        shift_d = byte_in[6:0];
                        if (bit_cnt_q == BITS_PER_BYTE - 4'd1) begin
                            bit_cnt_d  = 4'd0;
                            rx_data_d  = byte_in;
                            rx_valid_d = 1'b1;
                            phase_d    = 1'b0;
                            state_d    = WRITE_ACK;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end

                WRITE_ACK: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            sda_low_d = ~ACK_LEVEL;
                            phase_d   = 1'b1;
                        end else begin
                            sda_low_d = 1'b0;
                            phase_d   = 1'b0;
                            bit_cnt_d = 4'd0;
                            state_d   = WRITE;
                        end
                    end
                end

                READ: begin
`ifdef I2C_CLOCK_STRETCH_EN
                    // SDA already carries bit 7, so SCL may go now.
                    if (scl_low_q) begin
                        scl_low_d = 1'b0;
                    end
`endif
                    if (scl_fall) begin
                        if (bit_cnt_q == BITS_PER_BYTE) begin
                            sda_low_d = 1'b0;
                            bit_cnt_d = 4'd0;
                            phase_d   = 1'b0;
                            state_d   = READ_ACK;
                        end else begin
                            sda_low_d  = ~tx_shift_q[6];
                            tx_shift_d = {tx_shift_q[5:0], 1'b0};
                            bit_cnt_d  = bit_cnt_q + 4'd1;
                        end
                    end
                end

                READ_ACK: begin
`ifdef I2C_CLOCK_STRETCH_EN
                    if (stretch_q) begin
                        if (TxReady) begin
                            stretch_d = 1'b0;
                            load_req  = 1'b1;
                        end
                    end else
`endif
                    if (scl_rise) begin
                        if (sda_level == NACK_LEVEL) begin
                            sda_low_d = 1'b0;
                            state_d   = WAIT_STOP;
                        end else begin
                            phase_d = 1'b1;
                        end
                    end else if (scl_fall && phase_q) begin
                        phase_d  = 1'b0;
                        load_req = 1'b1;
                    end
                end

                WAIT_STOP: begin
                end

                default: begin
                    state_d = IDLE;
                end
            endcase

            // Fetch the next read byte and put its MSB on SDA; bit_cnt
            // counts bits already driven.
            if (load_req) begin
`ifdef I2C_CLOCK_STRETCH_EN
                if (!TxReady) begin
                    scl_low_d = 1'b1;
                    stretch_d = 1'b1;
                end else
`endif
                begin
                    tx_load_d  = 1'b1;
                    tx_shift_d = TxData[6:0];
                    sda_low_d  = ~TxData[7];
                    bit_cnt_d  = 4'd1;
                    state_d    = READ;
                end
            end
        end
    end

    // FSM and datapath registers; reset releases the bus immediately.
    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 7'd0;
            tx_shift_q  <= 7'd0;
            sda_low_q   <= 1'b0;
            rx_data_q   <= 8'd0;
            rx_valid_q  <= 1'b0;
            tx_load_q   <= 1'b0;
            busy_q      <= 1'b0;
            read_mode_q <= 1'b0;
            phase_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            tx_shift_q  <= tx_shift_d;
            sda_low_q   <= sda_low_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            tx_load_q   <= tx_load_d;
            busy_q      <= busy_d;
            read_mode_q <= read_mode_d;
            phase_q     <= phase_d;
        end
    end

`ifdef I2C_CLOCK_STRETCH_EN
    // Clock-stretch registers.
    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            scl_low_q <= 1'b0;
            stretch_q <= 1'b0;
        end else begin
            scl_low_q <= scl_low_d;
            stretch_q <= stretch_d;
        end
    end

    assign SCL_Low = scl_low_q;
`else
    assign SCL_Low = 1'b0;
`endif

    assign SDA_Low  = sda_low_q;
    assign RxData   = rx_data_q;
    assign RxValid  = rx_valid_q;
    assign TxLoad   = tx_load_q;
    assign Busy     = busy_q;
    assign ReadMode = read_mode_q;

endmodule

// File: tb/tb_i2c_target_responder.sv
// Bench for i2c_target_responder: a bit-banged I2C master on a wired-AND
// bus, a passive bus sniffer that decodes every 9-bit slot, and an RxValid
// monitor. Expected slots and received bytes come from a transaction-level
// model of the target and are queued when each transaction is issued.
module tb_i2c_target_responder;

    localparam int         H   = 8;       // SCL half period in system clocks
    localparam logic [6:0] TGT = 7'h42;

    logic       clock = 1'b0;
    logic       Reset;
    logic       scl_m, sda_m;
    logic       SDA_Low, SCL_Low, RxValid, TxLoad, Busy, ReadMode;
    logic [7:0] RxData, TxData;
`ifdef I2C_CLOCK_STRETCH_EN
    logic       TxReady;
`endif

    wire scl_line = scl_m & ~SCL_Low;
    wire sda_line = sda_m & ~SDA_Low;

    always #5 clock = ~clock;

    i2c_target_responder #(.TARGET_ADDR(TGT), .SYNC_STAGES(2)) dut (
        .clock   (clock),
        .Reset   (Reset),
        .SCL_In  (scl_line),
        .SDA_In  (sda_line),
        .SDA_Low (SDA_Low),
        .SCL_Low (SCL_Low),
        .RxData  (RxData),
        .RxValid (RxValid),
        .TxData  (TxData),
        .TxLoad  (TxLoad),
`ifdef I2C_CLOCK_STRETCH_EN
        .TxReady (TxReady),
`endif
        .Busy    (Busy),
        .ReadMode(ReadMode)
    );

    int         checks = 0;
    int         errors = 0;
    logic [8:0] exp_bus[$];   // {byte, ack level} per 9-clock slot
    logic [7:0] exp_rx[$];
    logic       sniff_en = 1'b1;
    logic [7:0] tx_src[8];    // bytes the user side returns, in order
    logic [7:0] wr_data[8];
    int         tx_base = 0;
    int         tx_load_cnt = 0;

    assign TxData = tx_src[3'(tx_load_cnt - tx_base)];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic scl_release();
        int k = 0;
        scl_m = 1'b1;
        while (scl_line !== 1'b1 && k < 3000) begin
            wait_clk(1);
            k++;
        end
        chk("scl_release_timeout", {31'd0, scl_line}, 32'd1);
    endtask

    task automatic start_cond();
        wait_clk(2); sda_m = 1'b1;
        wait_clk(H); scl_release();
        wait_clk(H); sda_m = 1'b0;
        wait_clk(H); scl_m = 1'b0;
    endtask

    task automatic stop_cond();
        wait_clk(2); sda_m = 1'b0;
        wait_clk(H - 2); scl_release();
        wait_clk(H); sda_m = 1'b1;
        wait_clk(H);
    endtask

    task automatic put_bit(input logic b);
        wait_clk(2); sda_m = b;
        wait_clk(H - 2); scl_release();
        wait_clk(H); scl_m = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d);
        for (int i = 7; i >= 0; i--) put_bit(d[i]);
    endtask

    task automatic clock_released(input int nbits);
        for (int i = 0; i < nbits; i++) put_bit(1'b1);
    endtask

    // Passive decoder: every 9th SCL rise since START closes one slot.
    task automatic sniffer();
        logic       sp = 1'b1, dp = 1'b1;
        int         n = 0;
        logic [8:0] sh = '0;
        logic [8:0] e;
        forever begin
            @(negedge clock);
            if (sp && scl_line && (dp != sda_line)) begin
                n = 0;
            end else if (!sp && scl_line) begin
                sh = {sh[7:0], sda_line};
                n++;
                if (n == 9) begin
                    n = 0;
                    if (sniff_en) begin
                        if (exp_bus.size() == 0) begin
                            chk("bus_unexpected_slot", {23'd0, sh}, 32'h1ff);
                        end else begin
                            e = exp_bus.pop_front();
                            chk("bus_byte_ack", {23'd0, sh}, {23'd0, e});
                        end
                    end
                end
            end
            sp = scl_line;
            dp = sda_line;
        end
    endtask

    task automatic user_monitor();
        forever begin
            @(negedge clock);
            if (TxLoad) tx_load_cnt++;
            if (RxValid && sniff_en) begin
                if (exp_rx.size() == 0) chk("rx_unexpected", {24'd0, RxData}, 32'hffff_ffff);
                else chk("rx_data", {24'd0, RxData}, {24'd0, exp_rx.pop_front()});
            end
        end
    endtask

    // Model: the target claims only TGT (never 0), ACKs every written byte,
    // returns tx_src bytes in order, and one TxLoad per byte read.
    task automatic do_write(input logic [6:0] a, input int n, input logic stop_after);
        logic hit = (a == TGT) && (a != 7'd0);
        exp_bus.push_back({a, 1'b0, ~hit});
        start_cond();
        send_byte({a, 1'b0});
        clock_released(1);
        chk("busy_after_addr", {31'd0, Busy}, {31'd0, hit});
        if (hit) begin
            chk("readmode_write", {31'd0, ReadMode}, 32'd0);
            for (int i = 0; i < n; i++) begin
                exp_rx.push_back(wr_data[i]);
                exp_bus.push_back({wr_data[i], 1'b0});
                send_byte(wr_data[i]);
                clock_released(1);
            end
        end
        if (stop_after) begin
            stop_cond();
            chk("busy_after_stop", {31'd0, Busy}, 32'd0);
        end
    endtask

    task automatic do_read(input logic [6:0] a, input int n);
        logic hit = (a == TGT) && (a != 7'd0);
        tx_base = tx_load_cnt;
        exp_bus.push_back({a, 1'b1, ~hit});
        start_cond();
        send_byte({a, 1'b1});
        clock_released(1);
        chk("busy_after_addr", {31'd0, Busy}, {31'd0, hit});
        if (hit) begin
            chk("readmode_read", {31'd0, ReadMode}, 32'd1);
            for (int i = 0; i < n; i++) begin
                exp_bus.push_back({tx_src[i], (i == n - 1)});
                clock_released(8);
                put_bit(i == n - 1);
            end
        end
        stop_cond();
        chk("busy_after_stop", {31'd0, Busy}, 32'd0);
        chk("txload_count", tx_load_cnt - tx_base, hit ? n : 0);
    endtask

    initial begin
        Reset = 1'b0;
        scl_m = 1'b1;
        sda_m = 1'b1;
`ifdef I2C_CLOCK_STRETCH_EN
        TxReady = 1'b1;
`endif
        for (int i = 0; i < 8; i++) begin
            tx_src[i]  = 8'h00;
            wr_data[i] = 8'h00;
        end
        fork
            sniffer();
            user_monitor();
            begin
                #800000;
                $display("FAIL watchdog actual=timeout required=finish");
                $fatal(1, "watchdog");
            end
        join_none

        wait_clk(4);
        chk("rst_sda_low", {31'd0, SDA_Low}, 32'd0);
        chk("rst_scl_low", {31'd0, SCL_Low}, 32'd0);
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        chk("rst_readmode", {31'd0, ReadMode}, 32'd0);
        chk("rst_rxdata", {24'd0, RxData}, 32'd0);
        chk("rst_pulses", {30'd0, RxValid, TxLoad}, 32'd0);
        Reset = 1'b1;
        wait_clk(4);

        // Write A5, 3C to our address.
        wr_data[0] = 8'hA5; wr_data[1] = 8'h3C;
        do_write(7'h42, 2, 1'b1);

        // Write to a foreign address: NACK, nothing received.
        wr_data[0] = 8'h77;
        do_write(7'h43, 1, 1'b1);

        // General call is never claimed.
        do_write(7'h00, 1, 1'b1);

        // Read 96, 0F; master ACKs the first, NACKs the second.
        tx_src[0] = 8'h96; tx_src[1] = 8'h0F;
        do_read(7'h42, 2);

        // Write 11 then repeated START into a read.
        wr_data[0] = 8'h11;
        do_write(7'h42, 1, 1'b0);
        tx_src[0] = 8'hC3; tx_src[1] = 8'h5A;
        do_read(7'h42, 2);
        chk("rx_after_rstart", {24'd0, RxData}, 32'h11);

        // Reset in the middle of the second read byte.
        tx_src[0] = 8'h5A; tx_src[1] = 8'h00;
        tx_base = tx_load_cnt;
        sniff_en = 1'b0;
        start_cond();
        send_byte({7'h42, 1'b1});
        clock_released(1);
        clock_released(8);
        put_bit(1'b0);
        clock_released(3);
        chk("sda_driven_before_reset", {31'd0, SDA_Low}, 32'd1);
        Reset = 1'b0;
        #1;
        chk("sda_released_on_reset", {31'd0, SDA_Low}, 32'd0);
        chk("busy_cleared_on_reset", {31'd0, Busy}, 32'd0);
        wait_clk(2);
        Reset = 1'b1;
        stop_cond();
        wait_clk(4);
        exp_bus.delete();
        exp_rx.delete();
        sniff_en = 1'b1;
        wr_data[0] = 8'h3E; wr_data[1] = 8'hC1;
        do_write(7'h42, 2, 1'b1);

        // Randomized transactions.
        for (int t = 0; t < 8; t++) begin
            int         kind = int'($urandom_range(0, 3));
            int         n    = int'($urandom_range(1, 4));
            logic [6:0] a;
            for (int i = 0; i < 8; i++) begin
                wr_data[i] = 8'($urandom);
                tx_src[i]  = 8'($urandom);
            end
            a = (kind == 3) ? 7'($urandom) : TGT;
            if (kind == 1 || (kind == 3 && $urandom_range(0, 1) == 1)) do_read(a, n);
            else do_write(a, n, 1'b1);
        end

`ifdef I2C_CLOCK_STRETCH_EN
        // User not ready for 40 clocks at the first load point of a read.
        begin
            int held = 0;
            tx_src[0] = 8'hB7; tx_src[1] = 8'h24;
            TxReady = 1'b0;
            fork
                do_read(7'h42, 2);
                begin
                    int k = 0;
                    while (!SCL_Low && k < 2000) begin wait_clk(1); k++; end
                    while (SCL_Low && held < 500) begin
                        wait_clk(1);
                        held++;
                        if (held == 40) TxReady = 1'b1;
                    end
                    TxReady = 1'b1;
                end
            join
            chk("stretch_len_40_to_44", {31'd0, (held >= 40 && held <= 44)}, 32'd1);
        end
`endif

        wait_clk(20);
        chk("bus_queue_drained", exp_bus.size(), 0);
        chk("rx_queue_drained", exp_rx.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_target_responder.md
Name: i2c_target_responder

Overview:
- I2C target (slave) that answers transactions generated by the team's I2C master and its baud-rate generator.
- Oversamples SCL/SDA with the system clock, detects START/STOP, matches a 7-bit address, ACKs, shifts in write bytes and shifts out read bytes.
- Sits between the open-drain pad logic and a simple byte-level user interface (register file or lab peripheral).

Parameters:
- TARGET_ADDR, 7'h42, 7-bit address this block responds to.
- SYNC_STAGES, 2, synchronizer flops on SCL_In/SDA_In (minimum 2).

Ports:
- clock  in  1  system clock; must be ≥ 8× SCL frequency; SCL high and low phases each ≥ 4 clock periods.
- Reset  in  1  asynchronous, active-low reset.
- SCL_In  in  1  SCL pad input.
- SDA_In  in  1  SDA pad input.
- SDA_Low  out  1  1 = pull SDA low (open-drain enable); 0 = release.
- SCL_Low  out  1  1 = stretch SCL low (optional feature; tied 0 when compiled out).
- RxData  out  8  last byte written by the master.
- RxValid  out  1  one-cycle pulse when RxData updates.
- TxData  in  8  next byte to return on a read.
- TxLoad  out  1  one-cycle pulse when TxData is sampled; user presents the following byte before the next TxLoad.
- Busy  out  1  high from an address match to STOP or repeated START.
- ReadMode  out  1  R/W bit of the current matched transaction.

Behaviour:
- Reset (Reset=0) forces state IDLE and clears SDA_Low, SCL_Low, RxData, RxValid, TxLoad, Busy and ReadMode to 0. Reset is allowed mid-transfer; the bus is released immediately.
- Inputs pass through SYNC_STAGES flops; one extra register yields rise/fall strobes. Event latency is SYNC_STAGES+1 clocks after the pad transition.
- START: SDA falls while SCL=1. STOP: SDA rises while SCL=1. Both are recognised in every state.
  - START (including repeated START) goes to ADDR with the bit counter cleared.
  - STOP goes to IDLE.
  - Either event releases SDA and deasserts Busy the same cycle.
- Data bits are sampled on the SCL rising strobe, MSB first. SDA_Low changes only on the SCL falling strobe.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits.
    - On the 8th rise: if bits[7:1]==TARGET_ADDR, latch ReadMode=bit0, set Busy, go to ADDR_ACK.
    - Otherwise go to WAIT_STOP.
  - ADDR_ACK: on the next fall assert SDA_Low (ACK); on the following fall:
    - if ReadMode=0, release SDA and go to WRITE;
    - if ReadMode=1, pulse TxLoad, latch TxData, drive bit7 (SDA_Low = ~bit) and go to READ.
  - WRITE: shift 8 bits; on the 8th rise RxData<=byte and RxValid pulses. On the next fall assert ACK (WRITE_ACK); on the following fall release SDA and return to WRITE with the counter cleared.
  - READ: on each fall drive the next bit; after bit0's fall, release SDA and go to READ_ACK.
  - READ_ACK: sample on rise.
    - SDA=0 (master ACK): on the fall pulse TxLoad, load TxData, drive bit7, go to READ.
    - SDA=1 (NACK): go to WAIT_STOP with SDA released.
  - WAIT_STOP: ignore SCL; leave only on STOP or START.
- Bit counter is 4 bits and wraps 8 to 0 at each byte boundary. General call (address 0) is not acknowledged.
- A simultaneous SCL and SDA change in the same clock is treated as data, not START/STOP.

Optional Feature:
- Macro: I2C_CLOCK_STRETCH_EN.
- When defined, input TxReady (1 bit) is added. At each TxLoad point, if TxReady=0, the block asserts SCL_Low at the SCL fall and holds it until TxReady=1. The byte is then loaded and SCL released 1 clock later, after SDA is already driven.
- When undefined, SCL_Low is constant 0, no TxReady port exists, and TxData is sampled unconditionally.

Decomposition:
- Package i2c_pkg holds:
  - the state enum (IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, WAIT_STOP);
  - the bit-count constant 8;
  - the ACK/NACK level constants.
- One sub-module, i2c_line_sync: synchronizer plus edge detect for SCL/SDA, emitting rise, fall, start and stop strobes.

Test Plan:
- Write to 0x42, data 0xA5, 0x3C, STOP -> ACK on address and both bytes; RxValid twice with RxData=0xA5 then 0x3C; Busy falls on STOP.
- Write to 0x43 -> no ACK (SDA released on 9th clock), no RxValid, Busy stays 0 until the next START.
- Read from 0x42 with TxData=0x96 then 0x0F; master ACKs byte 1 and NACKs byte 2 -> bus shows 0x96, 0x0F; TxLoad pulses twice; SDA released after the NACK.
- Write 0x42 with byte 0x11, then repeated START with read 0x42 -> RxData=0x11; ReadMode switches to 1; TxLoad is asserted after the second address ACK.
- Reset low in the middle of byte 2 of a read -> SDA_Low=0 within 1 clock; state IDLE; the next valid transaction is handled normally.
- With I2C_CLOCK_STRETCH_EN and TxReady=0 for 40 clocks on a read -> SCL_Low held about 40 clocks; data correct after release.
